aes_encrypt_core: RTL and testbench
===================================

Name: aes_encrypt_core

Overview:
Iterative AES-128 forward cipher, the encrypt-side counterpart of the team's decryption core. It performs one round per clk cycle and expands the round key on the fly alongside the state, so no key schedule is stored. It uses the same ce load/run/done protocol and the same byte packing as the decrypt path, so host glue can drive either core. There is no internal clock divider; it runs directly on clk.

Parameters:
NR, 10, number of rounds. Only 10 (AES-128) is legal; any other value must fail at elaboration.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (the block is in reset when reset=0)
ce  input  1  load strobe: high = capture inputs; deasserting it starts encryption
key  input  128  cipher key, packed w[0]=[127:96] .. w[3]=[31:0]; byte S(r,c) = [127-8*(4c+r) -: 8]
plaintext  input  128  message block, same packing as key
done  output  1  high when cyphertext is valid; held until ce rises
cyphertext  output  128  encrypted block, registered, same packing

Behaviour:
- Reset (reset=0, async): fsm=IDLE, round=0, done=0, cyphertext=0, state and round-key registers=0. Takes effect immediately, including mid-run.
- States: IDLE, LOAD, RUN, DONE.
  - IDLE: ce=1 -> LOAD. Otherwise stay; done stays 0.
  - LOAD: key_r<=key and pt_r<=plaintext on every edge while ce=1, so the last captured value wins. ce=0 -> RUN.
  - RUN: ce=1 -> LOAD (abort; no output update; done stays 0). Otherwise perform a round. After round NR -> DONE.
  - DONE: done=1 and cyphertext is held. ce=1 -> LOAD, and done falls on that edge.
- Round sequencing, with E0 = first edge in RUN:
  - E0: state<=pt_r^key_r, rk<=key_r, round<=1.
  - Ek (k=1..9): rk<=KE(rk,Rcon[k]); state<=MixColumns(ShiftRows(SubBytes(state)))^KE(rk,Rcon[k]); round<=k+1.
  - E10: same as Ek but without MixColumns. cyphertext<=result, done<=1, fsm<=DONE.
  - Latency: done rises on the 11th clk edge after ce is sampled low.
- KE (forward key expansion step): t = SubWord(RotWord(w3))^{Rcon,00,00,00}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Field arithmetic: GF(2^8) with polynomial 0x11b. xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0). The round counter is 4 bits and never exceeds 10.
- Input changes during RUN/DONE are ignored; only the LOAD capture is used.
- ce held high for a single cycle is sufficient: LOAD is entered, the inputs are captured once, and the run starts on the next edge.
- cyphertext changes only on the E10 edge (or on reset). done never pulses during an abort.

Decomposition:
- Package aes_pkg holds:
  - state_t (16-byte array) and word_t;
  - the 256-entry forward SBOX constant and an sbox() function;
  - the RCON constant array;
  - the xtime() and mixcolumn() functions;
  - an fsm_t enum {IDLE,LOAD,RUN,DONE}.
- One combinational sub-module, aes_fwd_round: inputs state, rk_in, rcon, last. Outputs next_state and rk_out (it contains KE, SubBytes, ShiftRows, MixColumns and AddRoundKey).
- The top holds only the FSM, counter and registers.

Test Plan:
1. FIPS-197 App. B. key=2b7e151628aed2a6abf7158809cf4f3c, plaintext=3243f6a8885a308d313198a2e0370734; pulse ce -> done rises exactly 11 edges after ce low; cyphertext=3925841d02dc09fbdc118597196a0b32.
2. FIPS-197 App. C.1. key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff -> cyphertext=69c4e0d86a7b0430d8cdb78070b4c55a. Check that the internal rk after E10 equals 13111d7fe3944a17f307a78b4d2b30c5.
3. Capture and ignore. Load vector 1 with ce high for 5 cycles, changing inputs on each of the first 4 and using vector 2 on the last -> C.1 result. Inputs toggled randomly during RUN -> result unchanged.
4. Abort. Raise ce at E5 with vector 1 loaded, then run vector 2 -> done stays 0 through the abort; final cyphertext=69c4e0d8...c55a; previous cyphertext is held until the new E10.
5. Reset mid-run. Assert reset=0 at E6 (asynchronous, between edges) -> done=0 and cyphertext=0 immediately; after release with ce=0 the block stays IDLE and done stays 0 indefinitely.
6. Back-to-back. Complete vector 1, hold DONE for 20 cycles (cyphertext stable), raise ce -> done falls on that edge; vector 2 completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constant tables and GF(2^8) helpers for the encrypt core.
package aes_pkg;

  typedef logic [15:0][7:0] state_t;
  typedef logic [31:0]      word_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 is never used (round 0 is the initial AddRoundKey); tail padded to a power of two.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are row 0 in [31:24] down to row 3 in [7:0].
  function automatic word_t mixcolumn(input word_t w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_fwd_round.sv
// One combinational AES forward round plus the matching on-the-fly key expansion step.
module aes_fwd_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] rk_out
);

  logic [127:0] sb;
  logic [127:0] mc;
  word_t        w0, w1, w2, w3;
  word_t        t;
  word_t        n0, n1, n2, n3;

  assign w0 = rk_in[127:96];
  assign w1 = rk_in[95:64];
  assign w2 = rk_in[63:32];
  assign w3 = rk_in[31:0];

  assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_out = {n0, n1, n2, n3};

  // SubBytes fused with ShiftRows: row r of column c takes the byte from column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
    end
    assign mc[127-32*c -: 32] = mixcolumn(sb[127-32*c -: 32]);
  end

  assign next_state = (last ? sb : mc) ^ rk_out;

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded alongside the state.
module aes_encrypt_core
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         done,
  output logic [127:0] cyphertext
);

  if (NR != 10) begin : g_nr_check
    $error("aes_encrypt_core: only NR=10 (AES-128) is supported");
  end

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   round;
  state_t       st;
  logic [127:0] rk;
  logic [127:0] key_r, pt_r;
  logic [127:0] rnd_state, rnd_rk;
  logic         last;
  logic         cap_en, run_en;

  assign last = (round == 4'(NR));

  aes_fwd_round u_round (
    .state      (st),
    .rk_in      (rk),
    .rcon       (RCON[round]),
    .last       (last),
    .next_state (rnd_state),
    .rk_out     (rnd_rk)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: if (ce) fsm_nxt = LOAD;
      LOAD: if (!ce) fsm_nxt = RUN;
      RUN: begin
        if (ce)        fsm_nxt = LOAD;
        else if (last) fsm_nxt = DONE;
      end
      DONE: if (ce) fsm_nxt = LOAD;
      default: fsm_nxt = IDLE;
    endcase
  end

  // Every state leaves for LOAD when ce is high, so ce alone qualifies the capture.
  always_comb begin
    cap_en = ce;
    run_en = (fsm == RUN) && !ce;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round      <= '0;
      done       <= 1'b0;
      cyphertext <= '0;
      st         <= '0;
      rk         <= '0;
      key_r      <= '0;
      pt_r       <= '0;
    end else if (cap_en) begin
      key_r <= key;
      pt_r  <= plaintext;
      round <= '0;
      done  <= 1'b0;
    end else if (run_en) begin
      if (round == 4'd0) begin
        st    <= pt_r ^ key_r;
        rk    <= key_r;
        round <= 4'd1;
      end else begin
        st <= rnd_state;
        rk <= rnd_rk;
        if (last) begin
          cyphertext <= rnd_state;
          done       <= 1'b1;
          round      <= '0;
        end else begin
          round <= round + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core with a textbook AES-128 reference model.
module tb_aes_encrypt_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         ce;
  logic [127:0] key, plaintext;
  logic         done;
  logic [127:0] cyphertext;

  aes_encrypt_core #(.NR(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .key        (key),
    .plaintext  (plaintext),
    .done       (done),
    .cyphertext (cyphertext)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int total = 0;
  int bad = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb_tab [256];
  logic [127:0] hold_val;
  int           hold_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived from the multiplicative inverse and the affine map, not copied from a table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p,
                                           output logic [127:0] lrk);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb_tab[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
        if (rnd < 10) begin
          s[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[0][c] = a0; s[1][c] = a1; s[2][c] = a2; s[3][c] = a3;
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        out[127-8*(4*c+r) -: 8] = s[r][c];
    lrk = {w[40], w[41], w[42], w[43]};
    return out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Holds ce for 'hold' cycles (random inputs until the last), drops it, then steps past the edge that samples ce low.
  task automatic load(input logic [127:0] k, input logic [127:0] p, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ce = 1'b1;
      if (i == hold - 1) begin
        key = k; plaintext = p;
      end else begin
        key = rnd128(); plaintext = rnd128();
      end
    end
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_done(input string name, input bit toggle);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!done && cyphertext !== hold_val) hold_err++;
      if (toggle) begin
        key = rnd128(); plaintext = rnd128();
      end
    end while (!done && n < 40);
    chk({name, "_latency"}, 128'(n), 128'd11);
  endtask

  // Monitor: pops one expectation per rising done.
  initial begin
    logic done_d;
    logic [127:0] e;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_d) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got ct %h with no expectation queued", cyphertext);
        end else begin
          e = exp_q.pop_front();
          chk("cyphertext", cyphertext, e);
        end
      end
      done_d = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [127:0] lrk, ect, rk_k, rk_p;
    int errs;
    reset = 1'b0; ce = 1'b0; key = '0; plaintext = '0;
    hold_val = '0; hold_err = 0;
    build_sbox();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_ct", cyphertext, 128'd0);
    @(negedge clk);
    reset = 1'b1;

    // Known-answer vectors
    exp_q.push_back(C1);
    load(K1, P1, 1);
    wait_done("kat_b", 1'b0);
    hold_val = C1;

    exp_q.push_back(C2);
    load(K2, P2, 1);
    wait_done("kat_c1", 1'b0);
    chk("rk_after_e10", dut.rk, RK2);
    hold_val = C2;

    // Multi-cycle capture; inputs scrambled while running
    exp_q.push_back(C2);
    load(K2, P2, 5);
    wait_done("capture", 1'b1);

    for (int i = 0; i < 6; i++) begin
      rk_k = rnd128(); rk_p = rnd128();
      ect = aes_ref(rk_k, rk_p, lrk);
      exp_q.push_back(ect);
      load(rk_k, rk_p, 1 + (i % 3));
      wait_done("random", i[0]);
      chk("random_rk", dut.rk, lrk);
      hold_val = ect;
    end

    // Abort at E5 then restart with the C.1 vector
    load(K1, P1, 1);
    errs = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done || cyphertext !== hold_val) errs++;
    end
    exp_q.push_back(C2);
    load(K2, P2, 1);
    if (done || cyphertext !== hold_val) errs++;
    wait_done("abort", 1'b0);
    chk("abort_hold", 128'(errs), 128'd0);
    hold_val = C2;

    // Asynchronous reset between E5 and E6
    load(rnd128(), rnd128(), 1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_done", 128'(done), 128'd0);
    chk("async_rst_ct", cyphertext, 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ce = 1'b0;
    errs = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || cyphertext !== 128'd0) errs++;
    end
    chk("idle_after_rst", 128'(errs), 128'd0);
    hold_val = '0;

    // Back-to-back with a long DONE hold
    exp_q.push_back(C1);
    load(K1, P1, 1);
    wait_done("b2b_first", 1'b0);
    hold_val = C1;
    errs = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!done || cyphertext !== C1) errs++;
      key = rnd128(); plaintext = rnd128();
    end
    chk("done_hold", 128'(errs), 128'd0);
    exp_q.push_back(C2);
    @(negedge clk);
    ce = 1'b1; key = K2; plaintext = P2;
    @(posedge clk);
    #1;
    chk("done_fall", 128'(done), 128'd0);
    chk("ct_kept", cyphertext, C1);
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
    wait_done("b2b_second", 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("hold_between_runs", 128'(hold_err), 128'd0);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
